// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MA/WB controls and data in, ID read ports and
// EX forwarding taps out. The pipeline drives as master, wb_regfile is the slave.
interface wb_regfile_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              MUX3_select;
  logic              regwrite_enable;
  logic [XLEN-1:0]   ALU_out;
  logic [XLEN-1:0]   read_data;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_valid;

  modport master (
    output MUX3_select, regwrite_enable, ALU_out, read_data, rd, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_rd, wb_valid
  );

  modport slave (
    input  MUX3_select, regwrite_enable, ALU_out, read_data, rd, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_rd, wb_valid
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32IM writeback stage and integer register file: selects the writeback value,
// commits it on the clock edge and serves two read ports with write-through bypass.
module wb_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input logic          CLK,
    input logic          RESET_N,
    wb_regfile_if.slave  bus
);

    if ((1 << ADDR_W) != NUM_REGS) begin : g_bad_cfg
        $error("wb_regfile: 2**ADDR_W must equal NUM_REGS");
    end

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] wb_data_d;
    logic            wr_en_d;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_d;

    always_comb begin
        wb_data_d = bus.MUX3_select ? bus.read_data : bus.ALU_out;
        wr_en_d   = RESET_N && bus.regwrite_enable && (bus.rd != '0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[bus.rd] <= wb_data_d;
        end
    end

    // x0 reads are forced to zero ahead of the bypass; reset blanks both ports.
    always_comb begin
        rs1_data_d = regs_q[bus.rs1_addr];
        if (!RESET_N || bus.rs1_addr == '0) begin
            rs1_data_d = '0;
        end else if (wr_en_d && bus.rs1_addr == bus.rd) begin
            rs1_data_d = wb_data_d;
        end
    end

    always_comb begin
        rs2_data_d = regs_q[bus.rs2_addr];
        if (!RESET_N || bus.rs2_addr == '0) begin
            rs2_data_d = '0;
        end else if (wr_en_d && bus.rs2_addr == bus.rd) begin
            rs2_data_d = wb_data_d;
        end
    end

    assign bus.rs1_data = rs1_data_d;
    assign bus.rs2_data = rs2_data_d;
    assign bus.wb_data  = wb_data_d;
    assign bus.wb_rd    = bus.rd;
    assign bus.wb_valid = wr_en_d;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and short random checks of wb_regfile against a behavioural model of
// the register file; expected values go through a queue and are popped at each check.
module tb_wb_regfile;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic CLK;
  logic RESET_N;

  wb_regfile_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  wb_regfile #(.XLEN(XLEN), .NUM_REGS(32), .ADDR_W(ADDR_W)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model [32];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push_exp(input logic [XLEN-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs);
    logic [XLEN-1:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_wb();
    return bus.MUX3_select ? bus.read_data : bus.ALU_out;
  endfunction

  function automatic logic exp_valid();
    return RESET_N && bus.regwrite_enable && (bus.rd != '0);
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (!RESET_N || a == '0) return '0;
    if (exp_valid() && a == bus.rd) return exp_wb();
    return model[a];
  endfunction

  // driver tasks
  task automatic drive(input logic sel, input logic we, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] ld, input logic [ADDR_W-1:0] rd_a,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    @(negedge CLK);
    bus.MUX3_select     = sel;
    bus.regwrite_enable = we;
    bus.ALU_out         = alu;
    bus.read_data       = ld;
    bus.rd              = rd_a;
    bus.rs1_addr        = r1;
    bus.rs2_addr        = r2;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    if (exp_valid()) model[bus.rd] = exp_wb();
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic check_ports(input string tag);
    push_exp(exp_read(bus.rs1_addr)); check({tag, "_rs1"}, bus.rs1_data);
    push_exp(exp_read(bus.rs2_addr)); check({tag, "_rs2"}, bus.rs2_data);
  endtask

  initial begin
    RESET_N = 1'b0;
    bus.MUX3_select = 1'b0; bus.regwrite_enable = 1'b0;
    bus.ALU_out = '0; bus.read_data = '0; bus.rd = '0;
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd7;
    clear_model();
    #1;

    // reset state
    push_exp(32'h0); check("rst_rs1", bus.rs1_data);
    push_exp(32'h0); check("rst_wb_valid", {31'b0, bus.wb_valid});
    step(); step();
    @(negedge CLK); RESET_N = 1'b1;

    // write x5, then asynchronous reset mid-cycle clears it before any edge
    drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd1, 5'd2);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    push_exp(32'hDEADBEEF); check("x5_written", bus.rs1_data);
    #2 RESET_N = 1'b0;
    clear_model();
    #1;
    push_exp(32'h0); check("x5_async_clear", bus.rs1_data);
    push_exp(32'h0); check("x5_async_clear_rs2", bus.rs2_data);

    // pending write aborted by reset; wb_data still follows inputs
    drive(1'b0, 1'b1, 32'h00000099, 32'h0, 5'd9, 5'd9, 5'd9);
    push_exp(32'h00000099); check("wb_data_in_reset", bus.wb_data);
    push_exp(32'h9); check("wb_rd_in_reset", {27'b0, bus.wb_rd});
    push_exp(32'h0); check("wb_valid_in_reset", {31'b0, bus.wb_valid});
    step();
    @(negedge CLK); RESET_N = 1'b1; #1;
    push_exp(32'h1); check("wb_valid_after_release", {31'b0, bus.wb_valid});
    bus.regwrite_enable = 1'b0; #1;
    push_exp(32'h0); check("x9_aborted", bus.rs1_data);
    bus.regwrite_enable = 1'b1;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
    push_exp(32'h00000099); check("x9_first_write", bus.rs1_data);
    push_exp(32'h0); check("x5_still_zero", bus.rs2_data);

    // writeback select and latency
    drive(1'b0, 1'b1, 32'h00000123, 32'h0000ABCD, 5'd7, 5'd7, 5'd7);
    push_exp(32'h00000123); check("wb_data_alu", bus.wb_data);
    step();
    drive(1'b1, 1'b0, 32'h00000123, 32'h0000ABCD, 5'd7, 5'd7, 5'd7);
    push_exp(32'h00000123); check("x7_alu", bus.rs1_data);
    drive(1'b1, 1'b1, 32'h00000123, 32'h0000ABCD, 5'd7, 5'd1, 5'd2);
    push_exp(32'h0000ABCD); check("wb_data_load", bus.wb_data);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    push_exp(32'h0000ABCD); check("x7_load", bus.rs2_data);

    // x0 hardwired
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    push_exp(32'h0); check("x0_before", bus.rs1_data);
    push_exp(32'h0); check("x0_wb_valid", {31'b0, bus.wb_valid});
    step();
    push_exp(32'h0); check("x0_after", bus.rs1_data);

    // bypass on both ports
    drive(1'b0, 1'b1, 32'h11111111, 32'h0, 5'd3, 5'd1, 5'd2);
    step();
    drive(1'b0, 1'b1, 32'h22222222, 32'h0, 5'd3, 5'd3, 5'd3);
    push_exp(32'h22222222); check("bypass_rs1", bus.rs1_data);
    push_exp(32'h22222222); check("bypass_rs2", bus.rs2_data);
    push_exp(32'h1); check("bypass_wb_valid", {31'b0, bus.wb_valid});
    step();

    // write disabled
    drive(1'b0, 1'b0, 32'h33333333, 32'h0, 5'd3, 5'd3, 5'd3);
    push_exp(32'h22222222); check("nowr_no_bypass", bus.rs1_data);
    push_exp(32'h0); check("nowr_wb_valid", {31'b0, bus.wb_valid});
    step();
    push_exp(32'h22222222); check("nowr_unchanged", bus.rs2_data);

    // walking pattern
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, (XLEN'(i) << 24) | XLEN'(i), 32'h0, ADDR_W'(i), 5'd0, 5'd0);
      step();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, ADDR_W'(i), ADDR_W'(32 - i));
      push_exp((XLEN'(i) << 24) | XLEN'(i)); check("walk_rs1", bus.rs1_data);
      push_exp((XLEN'(32 - i) << 24) | XLEN'(32 - i)); check("walk_rs2", bus.rs2_data);
    end

    // short random mix against the model
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            ADDR_W'($urandom_range(0, 31)), ADDR_W'($urandom_range(0, 31)),
            ADDR_W'($urandom_range(0, 31)));
      check_ports("rand");
      push_exp(exp_wb()); check("rand_wb_data", bus.wb_data);
      push_exp({31'b0, exp_valid()}); check("rand_wb_valid", {31'b0, bus.wb_valid});
      step();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MA/WB pipeline register: the writeback stage plus the integer register file of the RV32IM pipeline.
- Takes the registered writeback controls and data from MA/WB:
  - selects the writeback value (ALU result or load data);
  - commits it to a 32 x 32-bit register file on the clock edge;
  - serves the two ID-stage read ports, with write-to-read bypass so same-cycle RAW needs no stall.
- Exports the selected writeback value and destination for EX-stage forwarding.

Parameters:
- XLEN, 32, data width of registers and data paths.
- NUM_REGS, 32, number of architectural registers (x0..x31).
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W = NUM_REGS.

Ports:
- CLK  input  1  single system clock; all state updates on posedge.
- RESET_N  input  1  asynchronous active-low reset.
- MUX3_select  input  1  writeback source select from MA/WB: 0 = ALU_out, 1 = read_data.
- regwrite_enable  input  1  writeback write enable from MA/WB.
- ALU_out  input  XLEN  ALU result from MA/WB.
- read_data  input  XLEN  load data from MA/WB.
- rd  input  ADDR_W  destination register from MA/WB.
- rs1_addr  input  ADDR_W  ID read port 1 address.
- rs2_addr  input  ADDR_W  ID read port 2 address.
- rs1_data  output  XLEN  ID read port 1 data (combinational).
- rs2_data  output  XLEN  ID read port 2 data (combinational).
- wb_data  output  XLEN  selected writeback value, for forwarding.
- wb_rd  output  ADDR_W  writeback destination, for forwarding.
- wb_valid  output  1  high when a real write occurs this cycle: regwrite_enable AND rd != 0 AND RESET_N high.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - RESET_N low clears all NUM_REGS entries to 0 immediately, without waiting for CLK.
  - While RESET_N is low: rs1_data = rs2_data = 0, wb_valid = 0, and no write is committed on any CLK edge.
  - wb_data and wb_rd follow inputs combinationally regardless of reset.
- Writeback select:
  - wb_data = MUX3_select ? read_data : ALU_out, combinational.
  - wb_rd = rd.
- Write:
  - At posedge CLK with RESET_N high, regwrite_enable = 1 and rd != 0: regs[rd] <= wb_data.
  - Latency: 1 edge. The value is visible from storage after that edge.
- x0:
  - Never written; regwrite_enable with rd = 0 is a no-op.
  - Reads of address 0 always return 0, with no bypass.
- Read:
  - rsN_data is combinational from rsN_addr.
  - Bypass: if wb_valid = 1 and rsN_addr == rd, rsN_data = wb_data in the same cycle (write-through, new value).
  - Otherwise rsN_data = regs[rsN_addr].
- Simultaneous cases:
  - Both read ports may match rd; both bypass.
  - rs1_addr == rs2_addr returns identical data on both ports.
- Reset mid-operation:
  - RESET_N falling between edges aborts the pending write; the register stays 0.
  - RESET_N rising: the first write commits at the next posedge.
- No X propagation: uninitialised storage is impossible because reset clears everything.
- Width rule: no truncation or extension; all data is XLEN bits.

Test Plan:
- Reset clears state:
  - Stimulus: write x5 = 0xDEADBEEF, then pulse RESET_N low mid-cycle.
  - Required: rs1_data for x5 reads 0 immediately, before any CLK edge.
- Writeback select and latency:
  - Stimulus: MUX3_select = 0, ALU_out = 0x00000123, read_data = 0x0000ABCD, rd = 7, regwrite_enable = 1; one edge.
  - Required: x7 = 0x00000123.
  - Stimulus: repeat with MUX3_select = 1.
  - Required: x7 = 0x0000ABCD.
- x0 hardwired:
  - Stimulus: regwrite_enable = 1, rd = 0, ALU_out = 0xFFFFFFFF; rs1_addr = 0.
  - Required: rs1_data = 0 before and after the edge; wb_valid = 0.
- Bypass:
  - Stimulus: x3 holds 0x11111111; drive rd = 3, wb_data = 0x22222222, regwrite_enable = 1, rs1_addr = rs2_addr = 3.
  - Required: both ports read 0x22222222 in the same cycle, before the edge.
- Write disabled:
  - Stimulus: regwrite_enable = 0, rd = 3, data 0x33333333; one edge.
  - Required: x3 unchanged, no bypass, wb_valid = 0.
- Walking pattern:
  - Stimulus: write x1..x31 with value (i << 24 | i), then read all 31 through both ports.
  - Required: every read matches its written value.
